// File: rtl/booth_mul_issue_queue.sv
// Operand FIFO and issue sequencer in front of a radix-4 Booth multiplier.
// Optional watchdog: define BOOTH_ISSUE_WATCHDOG_EN to abort stalled multiplies after TIMEOUT cycles.
module booth_mul_issue_queue #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     async_rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     in_ready,
    output logic                     mul_valid,
    output logic [WIDTH-1:0]         mul_A,
    output logic [WIDTH-1:0]         mul_B,
    input  logic                     mul_ready,
    input  logic [2*WIDTH-1:0]       mul_R,
    output logic                     res_valid,
    output logic [2*WIDTH-1:0]       res_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   mem_a_r [DEPTH];
    logic [WIDTH-1:0]   mem_b_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
    logic [AW:0]        count_r, count_s;
    logic               in_ready_r, mul_valid_r, res_valid_r, busy_r, err_r;
    logic [WIDTH-1:0]   mul_a_r, mul_b_r;
    logic [2*WIDTH-1:0] res_data_r;
    logic               push_s, pop_s, done_s, timeout_s, launch_s;

    assign push_s   = in_valid & in_ready_r;
    assign pop_s    = (state_r == ISSUE);
    assign done_s   = (state_r == WAIT_DONE) & mul_ready;
    assign launch_s = (state_r == IDLE) & (state_s == ISSUE);

`ifdef BOOTH_ISSUE_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_ONE   = CW'(1);
    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT - 1);
    logic [CW-1:0] wd_cnt_r;

    // Watchdog counts cycles spent waiting on the multiplier; idle/issue keeps it cleared.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            wd_cnt_r <= '0;
        end else if (state_r == WAIT_BUSY || state_r == WAIT_DONE) begin
            wd_cnt_r <= wd_cnt_r + WD_ONE;
        end else begin
            wd_cnt_r <= '0;
        end
    end

    assign timeout_s = (state_r == WAIT_BUSY || state_r == WAIT_DONE) && (wd_cnt_r == WD_LIMIT);
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic; a completing multiply wins over a coincident timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (count_r != '0 && mul_ready) state_s = ISSUE;
                else                            state_s = IDLE;
            end
            ISSUE:     state_s = WAIT_BUSY;
            WAIT_BUSY: begin
                if (timeout_s)       state_s = IDLE;
                else if (!mul_ready) state_s = WAIT_DONE;
                else                 state_s = WAIT_BUSY;
            end
            WAIT_DONE: begin
                if (mul_ready)      state_s = IDLE;
                else if (timeout_s) state_s = IDLE;
                else                state_s = WAIT_DONE;
            end
            default:   state_s = IDLE;
        endcase
    end

    // Occupancy update for push, pop or both.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // FIFO storage needs no reset; occupancy and pointers qualify its contents.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_a_r[wr_ptr_r] <= in_a;
            mem_b_r[wr_ptr_r] <= in_b;
        end
    end

    // Control state, pointers and all registered outputs.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_r     <= IDLE;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            in_ready_r  <= 1'b0;
            mul_valid_r <= 1'b0;
            mul_a_r     <= '0;
            mul_b_r     <= '0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            in_ready_r  <= (count_s != CNT_FULL);
            mul_valid_r <= launch_s;
            res_valid_r <= done_s;
            busy_r      <= (state_s != IDLE);
            err_r       <= timeout_s & ~done_s;
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            // Operands load with the start pulse and stay put until the next launch.
            if (launch_s) begin
                mul_a_r <= mem_a_r[rd_ptr_r];
                mul_b_r <= mem_b_r[rd_ptr_r];
            end
            if (done_s) res_data_r <= mul_R;
        end
    end

    assign in_ready  = in_ready_r;
    assign mul_valid = mul_valid_r;
    assign mul_A     = mul_a_r;
    assign mul_B     = mul_b_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign count     = count_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule

// File: tb/tb_booth_mul_issue_queue.sv
// Directed, table-driven bench for booth_mul_issue_queue with a behavioural multiplier model.
module tb_booth_mul_issue_queue;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        async_rst_n;
    logic        in_valid;
    logic [31:0] in_a, in_b;
    logic        in_ready;
    logic        mul_valid;
    logic [31:0] mul_A, mul_B;
    logic        mul_ready;
    logic [63:0] mul_R;
    logic        res_valid;
    logic [63:0] res_data;
    logic [2:0]  count;
    logic        busy;
    logic        err;

    logic        model_ready;
    logic        hold;
    int          lat;
    logic signed [63:0] prod;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;
    vec_t vecs [8];
    logic [63:0] exp_q [$];

    booth_mul_issue_queue dut (
        .clk(clk), .async_rst_n(async_rst_n),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .mul_valid(mul_valid), .mul_A(mul_A), .mul_B(mul_B),
        .mul_ready(mul_ready), .mul_R(mul_R),
        .res_valid(res_valid), .res_data(res_data),
        .count(count), .busy(busy), .err(err)
    );

    always #5 clk = clk_en ? ~clk : clk;

    assign mul_ready = model_ready & ~hold;

    // Multiplier model: drops ready after a start pulse, returns the product LAT cycles later.
    initial begin
        model_ready = 1'b1;
        lat = 0;
        mul_R = 64'd0;
        prod = 64'sd0;
        forever begin
            @(negedge clk);
            if (!async_rst_n) begin
                model_ready = 1'b1;
                lat = 0;
            end else if (mul_valid) begin
                model_ready = 1'b0;
                lat = LAT;
                prod = $signed(mul_A) * $signed(mul_B);
            end else if (lat > 0) begin
                lat = lat - 1;
                if (lat == 0) begin
                    mul_R = prod;
                    model_ready = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic collect(input int n_exp, input int budget);
        int got = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (res_valid) begin
                got++;
                if (exp_q.size() > 0) chk("order", res_data, exp_q.pop_front());
            end
        end
        chk("res_count", 64'(got), 64'(n_exp));
        exp_q.delete();
    endtask

    task automatic wait_issue(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mul_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        async_rst_n = 1'b0;
        hold = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        async_rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int  k_res;
        bit  ok;
        int  n_errp, n_resp;

        vecs[0] = '{32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vecs[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
        vecs[6] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFFB};

        in_valid = 1'b0;
        in_a = 32'd0;
        in_b = 32'd0;
        hold = 1'b0;

        // Reset with the clock stopped: outputs must clear asynchronously.
        async_rst_n = 1'b1;
        #2 async_rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_mul_valid", 64'(mul_valid), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_res_data", res_data, 64'd0);
        chk("rst_mul_a", 64'(mul_A), 64'd0);
        #5 async_rst_n = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single operations from the vector table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = vecs[i].a;
            in_b = vecs[i].b;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            chk("pre_issue", 64'(mul_valid), 64'd0);
            chk("count_one", 64'(count), 64'd1);
            @(negedge clk);
            chk("issue_pulse", 64'(mul_valid), 64'd1);
            chk("issue_a", 64'(mul_A), 64'(vecs[i].a));
            chk("issue_b", 64'(mul_B), 64'(vecs[i].b));
            chk("issue_busy", 64'(busy), 64'd1);
            k_res = 0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (res_valid) begin
                    k_res = k;
                    break;
                end
            end
            chk("res_latency", 64'(k_res), 64'(LAT + 1));
            chk("res_data", res_data, vecs[i].p);
            @(negedge clk);
            chk("res_strobe_len", 64'(res_valid), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
        end

        // Fill with multiplier stalled: fifth pair must be dropped.
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = 32'(i * 2 + 1) ^ ((i == 1) ? 32'hFFFF_FFFF : 32'h0);
            in_b = 32'(i * 3 + 2);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        chk("fill_no_issue", 64'(mul_valid), 64'd0);
        // 1*2, (~3)*5 = -4*5, 5*8, 7*11
        exp_q.push_back(64'h0000_0000_0000_0002);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEC);
        exp_q.push_back(64'h0000_0000_0000_0028);
        exp_q.push_back(64'h0000_0000_0000_004D);
        hold = 1'b0;
        collect(4, 60);
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_in_ready", 64'(in_ready), 64'd1);

        // Push coinciding with the ISSUE pop at count=2.
        hold = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 32'h0000_0010;
        in_b = 32'h0000_0003;
        @(posedge clk);
        @(negedge clk);
        in_a = 32'hFFFF_FFFE;
        in_b = 32'h0000_0004;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pp_count_pre", 64'(count), 64'd2);
        hold = 1'b0;
        @(negedge clk);
        chk("pp_issue", 64'(mul_valid), 64'd1);
        chk("pp_count_issue", 64'(count), 64'd2);
        in_valid = 1'b1;
        in_a = 32'h0000_0006;
        in_b = 32'hFFFF_FFF9;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pp_count_post", 64'(count), 64'd2);
        exp_q.push_back(64'h0000_0000_0000_0030);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFD6);
        collect(3, 40);

        // Asynchronous reset while waiting on the multiplier.
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 32'h0000_0002;
        in_b = 32'h0000_0002;
        @(posedge clk);
        @(negedge clk);
        in_a = 32'h0000_0003;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_issue(ok);
        chk("mr_issue_seen", 64'(ok), 64'd1);
        hold = 1'b1;
        repeat (3) @(negedge clk);
        chk("mr_busy_before", 64'(busy), 64'd1);
        #2 async_rst_n = 1'b0;
        #1;
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_count", 64'(count), 64'd0);
        chk("mr_res_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        hold = 1'b0;
        async_rst_n = 1'b1;
        n_resp = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid || mul_valid) n_resp++;
        end
        chk("mr_no_activity", 64'(n_resp), 64'd0);
        chk("mr_in_ready", 64'(in_ready), 64'd1);

        // Multiplier that never finishes.
        @(negedge clk);
        in_valid = 1'b1;
        in_a = vecs[0].a;
        in_b = vecs[0].b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_issue(ok);
        chk("wd_issue_seen", 64'(ok), 64'd1);
        hold = 1'b1;
        n_errp = 0;
        n_resp = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (err) n_errp++;
            if (res_valid) n_resp++;
        end
        chk("wd_no_result", 64'(n_resp), 64'd0);
`ifdef BOOTH_ISSUE_WATCHDOG_EN
        chk("wd_err_pulses", 64'(n_errp), 64'd1);
        chk("wd_idle", 64'(busy), 64'd0);
        hold = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = vecs[7].a;
        in_b = vecs[7].b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_issue(ok);
        chk("wd_next_issue", 64'(ok), 64'd1);
        exp_q.push_back(vecs[7].p);
        collect(1, 20);
`else
        chk("wd_err_pulses", 64'(n_errp), 64'd0);
        chk("wd_stays_busy", 64'(busy), 64'd1);
        do_reset();
        chk("wd_reset_idle", 64'(busy), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
